// File: rtl/ro_status_reg_pkg.sv
// Shared constants and per-bit next-state helper
// for the read-only status register.
package ro_status_pkg;

  localparam int MAX_SYNC_STAGES = 3;

  // Live bits follow the event; sticky bits set on event,
  // clear on request, and the event wins a same-cycle tie.
  function automatic logic next_bit(
    input logic sticky,
    input logic set,
    input logic clr,
    input logic q
  );
    logic r;
    if (!sticky) begin
      r = set;
    end else begin
      r = set | (~clr & q);
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_status_reg_if.sv
// Bridge-side bundle of the status register:
// status input, read/clear controls, readback and IRQ.
interface ro_status_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] VALUE_IN;
  logic                  RD_STROBE;
  logic                  CLR_EN;
  logic [DATA_WIDTH-1:0] CLR_MASK;
  logic [DATA_WIDTH-1:0] IRQ_EN;
  logic [DATA_WIDTH-1:0] VALUE_OUT;
  logic                  IRQ;

  modport master (
    output VALUE_IN,
    output RD_STROBE,
    output CLR_EN,
    output CLR_MASK,
    output IRQ_EN,
    input  VALUE_OUT,
    input  IRQ
  );

  modport slave (
    input  VALUE_IN,
    input  RD_STROBE,
    input  CLR_EN,
    input  CLR_MASK,
    input  IRQ_EN,
    output VALUE_OUT,
    output IRQ
  );

endinterface

// File: rtl/ro_status_reg_sync_chain.sv
// Plain per-bit flop chain; a wire when STAGES is 0.
// Async active-high reset clears every stage.
module sync_chain #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign q_o = d_i;
  end else begin : g_chain
    logic [DATA_WIDTH-1:0] stg_q [STAGES];

    // Shift the raw input through the stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < STAGES; k++) begin
          stg_q[k] <= '0;
        end
      end else begin
        stg_q[0] <= d_i;
        for (int k = 1; k < STAGES; k++) begin
          stg_q[k] <= stg_q[k-1];
        end
      end
    end

    assign q_o = stg_q[STAGES-1];
  end

endmodule

// File: rtl/ro_status_reg.sv
// Status word capture with per-bit sync, edge,
// sticky/W1C, clear-on-read and maskable IRQ.
module ro_status_reg
  import ro_status_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SYNC_STAGES = 0,
  parameter logic [DATA_WIDTH-1:0] STICKY_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] EDGE_MASK   = '0,
  parameter bit                    COR_EN      = 1'b0
) (
  input logic        CLK,
  input logic        RST,
  ro_status_if.slave bus
);

  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("ro_status_reg: SYNC_STAGES must be 0..3");
  end

  logic [DATA_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] ev;
  logic [DATA_WIDTH-1:0] clr;
  logic [DATA_WIDTH-1:0] value_d;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  irq_d;
  logic                  irq_q;

  sync_chain #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (SYNC_STAGES)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (bus.VALUE_IN),
    .q_o   (s)
  );

  // Edge bits see only a 0->1 step; level bits pass through.
  assign ev = (EDGE_MASK & s & ~prev_q) | (~EDGE_MASK & s);

  // Masking with CLR_EN first keeps an idle X mask harmless.
  assign clr = ({DATA_WIDTH{bus.CLR_EN}} & bus.CLR_MASK)
             | {DATA_WIDTH{COR_EN & bus.RD_STROBE}};

  assign irq_d = |(value_q & bus.IRQ_EN);

  // Per-bit next status value.
  always_comb begin
    value_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      value_d[i] = next_bit(STICKY_MASK[i], ev[i], clr[i], value_q[i]);
    end
  end

  // Edge history, visible status and registered IRQ.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q  <= '0;
      value_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= s;
      value_q <= value_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.VALUE_OUT = value_q;
  assign bus.IRQ       = irq_q;

endmodule
